// File: rtl/axi4full_burst_slave_if.sv
// AXI4-full bus bundle between a burst master and the register-array slave.
// Only the channels and fields the slave actually uses are carried.
interface axi4full_burst_slave_if #(
  parameter int ID_W   = 1,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi4full_burst_slave.sv
// AXI4-full burst slave backed by a register-array memory; one transaction at a
// time, FIXED/INCR/WRAP bursts, byte strobes, ID echo and SLVERR reporting.
module axi4full_burst_slave #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 10
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  axi4full_burst_slave_if.slave  s_axi
);
  localparam int IW    = C_S_AXI_ID_WIDTH;
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int SW    = DW / 8;
  localparam int OFFS  = $clog2(SW);
  localparam int WORDS = 2 ** (AW - OFFS);

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_AW_ADDR, S_AR_ADDR, S_WDATA, S_WRESP, S_RDATA
  } state_e;

  state_e          state_q, state_d;
  logic            wr_prio_q, wr_prio_d;
  logic [IW-1:0]   id_q, id_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      beat_q, beat_d;
  logic [2:0]      size_q, size_d;
  logic [1:0]      burst_q, burst_d;
  logic            wlast_err_q, wlast_err_d;
  logic            awready_q, awready_d;
  logic            arready_q, arready_d;
  logic            wready_q, wready_d;
  logic            bvalid_q, bvalid_d;
  logic [IW-1:0]   bid_q, bid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic            rvalid_q, rvalid_d;
  logic            rlast_q, rlast_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic [IW-1:0]   rid_q, rid_d;

  logic [DW-1:0]   mem [WORDS];
  logic            cfg_err, mem_we, wlast_bad;
  logic [AW-1:0]   step, wrap_mask, next_addr;

  // Illegal burst type, oversize beat or a WRAP length the boundary maths cannot express.
  always_comb begin
    cfg_err = (burst_q == 2'b11) || (int'(size_q) > OFFS);
    if (burst_q == BURST_WRAP && !(len_q inside {8'd1, 8'd3, 8'd7, 8'd15}))
      cfg_err = 1'b1;
  end

  always_comb begin
    step      = AW'(1) << size_q;
    wrap_mask = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);
    case (burst_q)
      BURST_INCR: next_addr = addr_q + step;
      BURST_WRAP: next_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
      default:    next_addr = addr_q;
    endcase
  end

  assign wlast_bad = s_axi.wlast != (beat_q == len_q);

  always_comb begin
    // NOTE: every _d starts from its _q (or idle value) so no branch can infer a latch.
    state_d     = state_q;
    wr_prio_d   = wr_prio_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    beat_d      = beat_q;
    size_d      = size_q;
    burst_d     = burst_q;
    wlast_err_d = wlast_err_q;
    awready_d   = 1'b0;
    arready_d   = 1'b0;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    rvalid_d    = rvalid_q;
    rlast_d     = rlast_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rid_d       = rid_q;
    mem_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (s_axi.awvalid && (!s_axi.arvalid || wr_prio_q)) begin
          state_d   = S_AW_ADDR;
          awready_d = 1'b1;
          if (s_axi.arvalid) wr_prio_d = 1'b0;
        end else if (s_axi.arvalid) begin
          state_d   = S_AR_ADDR;
          arready_d = 1'b1;
          if (s_axi.awvalid) wr_prio_d = 1'b1;
        end
      end
      S_AW_ADDR: begin
        if (s_axi.awvalid) begin
          id_d        = s_axi.awid;
          addr_d      = s_axi.awaddr;
          len_d       = s_axi.awlen;
          size_d      = s_axi.awsize;
          burst_d     = s_axi.awburst;
          beat_d      = 8'd0;
          wlast_err_d = 1'b0;
          wready_d    = 1'b1;
          state_d     = S_WDATA;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_AR_ADDR: begin
        if (s_axi.arvalid) begin
          rid_d   = s_axi.arid;
          addr_d  = s_axi.araddr;
          len_d   = s_axi.arlen;
          size_d  = s_axi.arsize;
          burst_d = s_axi.arburst;
          beat_d  = 8'd0;
          state_d = S_RDATA;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WDATA: begin
        if (s_axi.wvalid && wready_q) begin
          mem_we = !cfg_err;
          if (wlast_bad) wlast_err_d = 1'b1;
          if (beat_q == len_q) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bid_d    = id_q;
            bresp_d  = (cfg_err || wlast_err_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
            state_d  = S_WRESP;
          end else begin
            beat_d = beat_q + 8'd1;
            addr_d = next_addr;
          end
        end
      end
      S_WRESP: begin
        if (bvalid_q && s_axi.bready) begin
          bvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_RDATA: begin
        // First cycle loads beat 0; afterwards each handshake loads the following beat.
        if (!rvalid_q) begin
          rvalid_d = 1'b1;
          rdata_d  = cfg_err ? '0 : mem[addr_q[AW-1:OFFS]];
          rresp_d  = cfg_err ? RESP_SLVERR : RESP_OKAY;
          rlast_d  = (beat_q == len_q);
        end else if (s_axi.rready) begin
          if (rlast_q) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            state_d  = S_IDLE;
          end else begin
            addr_d  = next_addr;
            beat_d  = beat_q + 8'd1;
            rdata_d = cfg_err ? '0 : mem[next_addr[AW-1:OFFS]];
            rlast_d = (beat_q + 8'd1 == len_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q     <= S_IDLE;
      wr_prio_q   <= 1'b1;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      wlast_err_q <= 1'b0;
      awready_q   <= 1'b0;
      arready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= '0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= '0;
      rid_q       <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge value of the others.
      state_q     <= state_d;
      wr_prio_q   <= wr_prio_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      wlast_err_q <= wlast_err_d;
      awready_q   <= awready_d;
      arready_q   <= arready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      rid_q       <= rid_d;
    end
  end

  // NOTE: memory has no reset branch; contents survive reset and it maps to plain storage.
  always_ff @(posedge S_AXI_ACLK) begin
    if (mem_we && S_AXI_ARESETN) begin
      for (int b = 0; b < SW; b++) begin
        if (s_axi.wstrb[b]) mem[addr_q[AW-1:OFFS]][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
      end
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.arready = arready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bid     = bid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rlast   = rlast_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rid     = rid_q;
endmodule

// File: doc/axi4full_burst_slave.md
Name: axi4full_burst_slave

Overview:
AXI4-full memory-mapped slave that answers burst writes and reads from an on-chip register-array memory. It is the responder on the S00_AXI port, driven by the AXI master VIP in the block-level BFM design. It supports one outstanding transaction at a time, with FIXED, INCR and WRAP bursts, byte strobes, ID echo and SLVERR reporting. USER, LOCK, CACHE, PROT, QOS and REGION are not implemented; the BD drives them and they are left unconnected.

Parameters:
C_S_AXI_ID_WIDTH, 1, width of AWID/BID/ARID/RID
C_S_AXI_DATA_WIDTH, 32, data bus width in bits (32 or 64)
C_S_AXI_ADDR_WIDTH, 10, byte-address width; memory = 2^ADDR_WIDTH bytes

Ports:
S_AXI_ACLK in 1 single clock; all logic on rising edge
S_AXI_ARESETN in 1 synchronous, active-low reset
S_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST in ID/ADDR/8/3/2 write address fields
S_AXI_AWVALID / S_AXI_AWREADY in/out 1 write address handshake
S_AXI_WDATA / S_AXI_WSTRB / S_AXI_WLAST in DATA/DATA/8/1 write data beat
S_AXI_WVALID / S_AXI_WREADY in/out 1 write data handshake
S_AXI_BID / S_AXI_BRESP out ID/2 write response
S_AXI_BVALID / S_AXI_BREADY out/in 1 write response handshake
S_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST in ID/ADDR/8/3/2 read address fields
S_AXI_ARVALID / S_AXI_ARREADY in/out 1 read address handshake
S_AXI_RID/RDATA/RRESP/RLAST out ID/DATA/2/1 read data beat
S_AXI_RVALID / S_AXI_RREADY out/in 1 read data handshake

Behaviour:
- Reset (ARESETN low at a clock edge): all READY/VALID low, RLAST 0, RDATA 0, BRESP/RRESP 0, BID/RID 0, FSM to IDLE, priority flag set to "write first". Memory is not cleared. Reset mid-burst abandons the burst; outputs are low on the next edge.
- FSM states:
  - IDLE: arbitrates AWVALID/ARVALID.
  - ADDR: AWREADY or ARREADY is high for exactly 1 cycle (registered), so the handshake completes 1 cycle after VALID is seen. ID, ADDR, LEN, SIZE and BURST are latched.
  - WDATA, then WRESP, then IDLE.
  - RDATA, then IDLE.
- Arbitration: simultaneous AWVALID and ARVALID in IDLE is resolved round-robin. The first conflict after reset goes to the write; the flag toggles after each conflict win. A lone request is taken immediately.
- WDATA:
  - WREADY is held high.
  - On each WVALID&WREADY, the bytes enabled by WSTRB are written to mem[addr[ADDR_WIDTH-1:log2(DW/8)]], then the address advances.
  - The burst ends after AWLEN+1 beats by count. If WLAST disagrees with the count on any beat, the error flag is set.
- Address update per beat, with step = 2^SIZE:
  - FIXED: address unchanged.
  - INCR: addr + step; upper address bits are ignored, so the address wraps modulo memory size.
  - WRAP: addr + step, wrapping within the aligned boundary of (LEN+1)*step. LEN must be 1, 3, 7 or 15; any other value sets the error flag.
- Errors:
  - BURST=2'b11, SIZE > log2(DW/8), or a bad WRAP length: beats are still consumed but no memory write; BRESP=2'b10.
  - WLAST mismatch also gives BRESP=2'b10; writes still occur.
  - Otherwise BRESP=2'b00.
- WRESP: BVALID=1, with BID = latched AWID. BID and BRESP are held stable until BREADY; BVALID drops on the cycle after the handshake.
- RDATA:
  - First RVALID appears 1 cycle after the ARREADY handshake.
  - RDATA, RRESP and RLAST are registered and held while RVALID&!RREADY.
  - On handshake, the next beat is loaded on the following edge, giving 1 beat/cycle with RREADY held high.
  - RLAST=1 only on beat ARLEN+1. RID = latched ARID.
  - Error cases return RDATA=0 and RRESP=2'b10 on every beat.
- AxLEN=0 is a single beat: WLAST is expected on beat 1; RLAST=1 on the only beat.

Test Plan:
1. INCR write, ID 0, addr 0x0, LEN 7, SIZE 2, data 1..8, WSTRB 0xF; then an INCR read of the same burst. Expect BRESP 0, RDATA 1..8, RLAST only on beat 8, RID 0.
2. WRAP write, LEN 3, addr 0x08, data A..D. Expect word reads at 0x08/0x0C/0x00/0x04 to return A/B/C/D.
3. Stall read burst 1 with RREADY low for 3 cycles on beat 4, and hold BREADY low for 5 cycles on the write. Expect RDATA, RLAST, BID and BRESP stable throughout and no beat lost or duplicated.
4. Simultaneous AWVALID and ARVALID from IDLE after reset: expect the write to be served first. On the next simultaneous request: expect the read to be served first.
5. 0xAABBCCDD at 0x10, then WSTRB 0x3 with data 0x11223344. Expect a read of 0x10 to return 0xAABB3344.
6. AWBURST 2'b11, LEN 1: expect BRESP 2'b10 and memory unchanged. WLAST asserted on beat 2 of LEN 3: expect BRESP 2'b10. ARSIZE 3 on a 32-bit bus: expect RRESP 2'b10 and RDATA 0.
